// File: rtl/spi_slave.sv
// SPI responder: oversamples sclk/CS/MOSI in the clk domain, shifts a buffered byte out on MISO
// and assembles received bytes MSB first. Handles all four CPOL/CPHA modes and back-to-back bytes.
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       CPOL,
    input  logic       CPHA,
    input  logic       sclk,
    input  logic       CS,
    input  logic       MOSI,
    output logic       MISO,
    input  logic [7:0] Tx_byte,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic [7:0] Rx_byte,
    output logic       rx_valid,
    output logic       tx_underrun,
    output logic       busy
);
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    logic [STAGES-1:0] sclk_sync_q;
    logic [STAGES-1:0] cs_sync_q;
    logic [STAGES-1:0] mosi_sync_q;
    logic              sclk_prev_q;
    logic              rise_q;
    logic              fall_q;
    logic              cs_q;
    logic              mosi_q;

    state_t     state_q, state_d;
    logic       cpol_q, cpol_d;
    logic       cpha_q, cpha_d;
    logic [2:0] cnt_q, cnt_d;
    logic       done_q, done_d;
    logic [7:0] rx_sr_q, rx_sr_d;
    logic [7:0] tx_sr_q, tx_sr_d;
    logic [7:0] hold_q, hold_d;
    logic       tx_ready_q, tx_ready_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_valid_q, rx_valid_d;
    logic       underrun_q, underrun_d;

    logic       lead_edge;
    logic       trail_edge;
    logic       sample_edge;
    logic       shift_edge;
    logic       byte_load;

    // Edge pulses are registered one cycle past the synchronizer; CS and MOSI get the same
    // extra delay so all three stay aligned with each other.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            cs_q        <= 1'b1;
            mosi_q      <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[STAGES-2:0], CS};
            mosi_sync_q <= {mosi_sync_q[STAGES-2:0], MOSI};
            sclk_prev_q <= sclk_sync_q[STAGES-1];
            rise_q      <= sclk_sync_q[STAGES-1] & ~sclk_prev_q;
            fall_q      <= ~sclk_sync_q[STAGES-1] & sclk_prev_q;
            cs_q        <= cs_sync_q[STAGES-1];
            mosi_q      <= mosi_sync_q[STAGES-1];
        end
    end

    assign lead_edge   = cpol_q ? fall_q : rise_q;
    assign trail_edge  = cpol_q ? rise_q : fall_q;
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            cnt_q      <= 3'd0;
            done_q     <= 1'b0;
            rx_sr_q    <= 8'h00;
            tx_sr_q    <= 8'h00;
            hold_q     <= 8'h00;
            tx_ready_q <= 1'b1;
            rx_byte_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            rx_sr_q    <= rx_sr_d;
            tx_sr_q    <= tx_sr_d;
            hold_q     <= hold_d;
            tx_ready_q <= tx_ready_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            underrun_q <= underrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        cnt_d      = cnt_q;
        done_d     = done_q;
        rx_sr_d    = rx_sr_q;
        tx_sr_d    = tx_sr_q;
        hold_d     = hold_q;
        tx_ready_d = tx_ready_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = 1'b0;
        underrun_d = 1'b0;
        byte_load  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!cs_q) begin
                    state_d = XFER;
                    cpol_d  = CPOL;
                    cpha_d  = CPHA;
                    cnt_d   = 3'd0;
                    done_d  = 1'b0;
                    // CPHA=1 defers the load to the first leading edge, where bit 7 is launched.
                    if (!CPHA) begin
                        byte_load = 1'b1;
                    end else begin
                        tx_sr_d = 8'h00;
                    end
                end
            end
            XFER: begin
                if (cs_q) begin
                    state_d = IDLE;
                end else if (sample_edge) begin
                    rx_sr_d = {rx_sr_q[6:0], mosi_q};
                    if (cnt_q == 3'd7) begin
                        rx_byte_d  = {rx_sr_q[6:0], mosi_q};
                        rx_valid_d = 1'b1;
                        cnt_d      = 3'd0;
                        done_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else if (shift_edge) begin
                    if ((cnt_q == 3'd0) && (cpha_q || done_q)) begin
                        byte_load = 1'b1;
                    end else begin
                        tx_sr_d = {tx_sr_q[6:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (byte_load) begin
            if (!tx_ready_q) begin
                tx_sr_d    = hold_q;
                tx_ready_d = 1'b1;
            end else begin
                tx_sr_d    = 8'h00;
                underrun_d = 1'b1;
            end
        end

        // A load coinciding with a byte load refills the slot the byte load just emptied.
        if (tx_load && (tx_ready_q || byte_load)) begin
            hold_d     = Tx_byte;
            tx_ready_d = 1'b0;
        end
    end

    assign MISO        = (state_q == XFER) & tx_sr_q[7];
    assign busy        = (state_q == XFER);
    assign tx_ready    = tx_ready_q;
    assign Rx_byte     = rx_byte_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;

endmodule
